// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial add scheduler: FSM encodings, default
// sizes and the round-robin grant search.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int MAX_NREQ  = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // First valid index at or after ptr (wrapping modulo nreq); -1 when none.
  // Scanning from the far end lets the closest hit win without a break.
  function automatic int rr_pick(input logic [MAX_NREQ-1:0] valid,
                                 input int ptr, input int nreq);
    int idx;
    rr_pick = -1;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        idx = ptr + k;
        if (idx >= nreq) idx = idx - nreq;
        if (valid[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/serial_add_cell.sv
// One bit-serial full adder with a registered carry; clr zeroes the carry
// synchronously so each operation starts from carry-in 0.
module serial_add_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry
);

  logic carry_q;

  assign s     = a ^ b ^ carry_q;
  assign carry = (a & b) | (a & carry_q) | (b & carry_q);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= carry;
    end
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin arbiter and sequencer sharing one serial add cell among NREQ
// requesters. Define SERIAL_ADD_SAT_EN to saturate the sum on carry-out.
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  localparam int CNTW = $clog2(WIDTH);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   own_id;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   ptr_nxt;
  logic             last_bit;
  logic             cell_s;
  logic             cell_carry;
  int               pick;

`ifdef SERIAL_ADD_SAT_EN
  function automatic logic [WIDTH-1:0] sum_out(input logic [WIDTH-1:0] s,
                                                input logic c);
    return c ? {WIDTH{1'b1}} : s;
  endfunction
`else
  function automatic logic [WIDTH-1:0] sum_out(input logic [WIDTH-1:0] s);
    return s;
  endfunction
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pick    = rr_pick(MAX_NREQ'(req_valid), int'(rr_ptr), NREQ);
    if (pick >= 0) begin
      gnt_vld = 1'b1;
      gnt_idx = IDW'(pick);
    end
  end

  assign ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
  assign req_ready = (state == ST_IDLE && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;
  assign busy      = (state != ST_IDLE);
  assign last_bit  = (cnt == CNTW'(WIDTH - 1));
  assign res_nxt   = {cell_s, res_sh[WIDTH-1:1]};

  serial_add_cell u_cell (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == ST_IDLE),
    .en    (state == ST_SHIFT),
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .s     (cell_s),
    .carry (cell_carry)
  );

  // Control and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            cnt    <= '0;
            rr_ptr <= ptr_nxt;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt + CNTW'(1);
          if (last_bit) begin
            state     <= ST_DONE;
            rsp_valid <= 1'b1;
            rsp_id    <= own_id;
`ifdef SERIAL_ADD_SAT_EN
            rsp_sum   <= sum_out(res_nxt, cell_carry);
`else
            rsp_sum   <= sum_out(res_nxt);
`endif
            rsp_cout  <= cell_carry;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand and result shift registers; contents are don't-care outside SHIFT
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && gnt_vld) begin
      a_sh   <= req_a[gnt_idx*WIDTH +: WIDTH];
      b_sh   <= req_b[gnt_idx*WIDTH +: WIDTH];
      own_id <= gnt_idx;
    end else if (state == ST_SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler (WIDTH=8, NREQ=4); honours
// SERIAL_ADD_SAT_EN when computing expected sums.
module tb_serial_add_scheduler;

  localparam int W = 8;
  localparam int N = 4;
`ifdef SERIAL_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t tbl[9];

  serial_add_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] xs(input logic [7:0] s, input logic c);
    return (SAT && c) ? 8'hFF : s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  // Waits (bounded) for rsp_valid, returning cycles waited starting from lat0.
  task automatic wait_rsp(input int lat0, output int lat);
    lat = lat0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_single(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] es, input logic ec, input bit chg);
    int lat;
    @(negedge clk);
    req_valid = '0;
    req_valid[id] = 1'b1;
    set_ops(id, a, b);
    #1;
    chk("grant_onehot", 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    req_valid[id] = 1'b0;
    if (chg) req_a[id*W +: W] = 8'hAA;
    #1;
    chk("ready_low_in_shift", 32'(req_ready), 32'd0);
    chk("busy_in_shift", 32'(busy), 32'd1);
    wait_rsp(1, lat);
    chk("latency", 32'(lat), 32'd9);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_sum", 32'(rsp_sum), 32'(es));
    chk("rsp_cout", 32'(rsp_cout), 32'(ec));
    @(negedge clk);
    chk("valid_drop", 32'(rsp_valid), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int ng;
    int nr;
    int grants[5];
    int exp_order[5];
    logic [7:0] rr_sum[4];
    logic       rr_c[4];

    tbl[0] = '{2, 8'h3C, 8'h15, 8'h51, 1'b0};
    tbl[1] = '{0, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{1, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{3, 8'hAA, 8'h55, 8'hFF, 1'b0};
    tbl[4] = '{1, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[5] = '{0, 8'h7F, 8'h01, 8'h80, 1'b0};
    tbl[6] = '{2, 8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[7] = '{2, 8'h01, 8'h02, 8'h03, 1'b0};
    tbl[8] = '{2, 8'h0F, 8'h01, 8'h10, 1'b0};

    exp_order = '{0, 1, 2, 3, 0};
    rr_sum = '{8'hFE, 8'h01, 8'h00, 8'h46};
    rr_c   = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    rst = 1'b0;

    // Round-robin with all requesters valid; requester 0 leaves a carry of 1
    // behind that must not reach requester 1's 0x01+0x00.
    @(negedge clk);
    set_ops(0, 8'hFF, 8'hFF);
    set_ops(1, 8'h01, 8'h00);
    set_ops(2, 8'h80, 8'h80);
    set_ops(3, 8'h12, 8'h34);
    req_valid = 4'hF;
    ng = 0;
    nr = 0;
    for (int cyc = 0; cyc < 80 && nr < 5; cyc++) begin
      #1;
      if (req_ready != '0 && ng < 5) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) grants[ng] = i;
        ng++;
      end
      if (rsp_valid) begin
        chk("rr_rsp_id", 32'(rsp_id), 32'(exp_order[nr]));
        chk("rr_rsp_sum", 32'(rsp_sum), 32'(xs(rr_sum[exp_order[nr]], rr_c[exp_order[nr]])));
        chk("rr_rsp_cout", 32'(rsp_cout), 32'(rr_c[exp_order[nr]]));
        nr++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_num_rsp", 32'(nr), 32'd5);
    chk("rr_num_grants", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk("rr_grant_order", 32'(grants[i]), 32'(exp_order[i]));
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      do_single(tbl[i].id, tbl[i].a, tbl[i].b, xs(tbl[i].s, tbl[i].c), tbl[i].c, 1'b0);

    // Operand change after grant is ignored
    do_single(1, 8'h10, 8'h01, 8'h11, 1'b0, 1'b1);

    // Backpressure: hold DONE for 5 cycles while requester 0 waits
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b1000;
    set_ops(3, 8'h40, 8'h22);
    #1;
    chk("bp_grant3", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = 4'b0001;
    set_ops(0, 8'h05, 8'h07);
    #1;
    chk("bp_no_ready_shift", 32'(req_ready), 32'd0);
    wait_rsp(1, lat);
    chk("bp_latency", 32'(lat), 32'd9);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_sum_held", 32'(rsp_sum), 32'h62);
      chk("bp_id_held", 32'(rsp_id), 32'd3);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_no_ready_done", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'b0001);
    chk("bp_valid_dropped", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(1, lat);
    chk("bp2_latency", 32'(lat), 32'd9);
    chk("bp2_id", 32'(rsp_id), 32'd0);
    chk("bp2_sum", 32'(rsp_sum), 32'h0C);
    @(negedge clk);

    // Reset mid-SHIFT after granting requester 2 (rr_ptr would be 3)
    @(negedge clk);
    req_valid = 4'b0100;
    set_ops(2, 8'h33, 8'h44);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 4'b1001;
    set_ops(0, 8'h01, 8'h01);
    set_ops(3, 8'h77, 8'h77);
    #1;
    chk("rstmid_ptr_zero", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(1, lat);
    chk("rstmid_latency", 32'(lat), 32'd9);
    chk("rstmid_id", 32'(rsp_id), 32'd0);
    chk("rstmid_sum", 32'(rsp_sum), 32'h02);
    chk("rstmid_cout", 32'(rsp_cout), 32'd0);
    @(negedge clk);
    chk("rstmid_no_response_left", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
Shares one bit-serial full-adder datapath among NREQ requesters.
- Round-robin arbiter grants one requester and captures its parallel A/B operands.
- Operands are streamed LSB-first through the serial adder for WIDTH cycles, with the carry cleared at the start of each operation.
- The assembled WIDTH-bit sum and carry-out are returned on a valid/ready response channel tagged with the requester id.
- Sits between parallel-operand clients and the serial add cell; it is the sequencer and arbiter for that cell.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be >= 2.
- NREQ, 4, number of requesters; must be >= 2.
- IDW, $clog2(NREQ), width of the requester id (derived).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, packed the same way as req_a.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_sum  output  WIDTH  A+B modulo 2^WIDTH.
- rsp_cout  output  1  final carry-out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, carry=0, bit counter=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, req_ready=0.
- rst has priority over everything. Reset mid-operation aborts it: no response is produced and the captured operands are discarded.
- States:
  - IDLE: if any req_valid is high, grant g = first index with req_valid high, searching rr_ptr, rr_ptr+1, ... modulo NREQ. req_ready[g]=1 is combinational in IDLE only.
    - On that edge: capture A and B of g into shift registers, store g as the id, clear carry and counter, set rr_ptr=(g+1) mod NREQ, go to SHIFT.
    - If no req_valid is high, stay in IDLE; req_ready=0.
  - SHIFT: each cycle computes s = a[0]^b[0]^carry and carry' = majority(a[0], b[0], carry).
    - s is shifted into the MSB of the result register, which shifts right; the operand registers shift right.
    - The counter increments. After the WIDTH-th bit, go to DONE with rsp_sum=result and rsp_cout=carry'.
    - req_ready=0 throughout.
  - DONE: rsp_valid=1; rsp_id, rsp_sum and rsp_cout are held stable until rsp_ready is high. On rsp_valid&&rsp_ready go to IDLE and drop rsp_valid.
    - No new grant occurs in the DONE cycle; the earliest next grant is the cycle after the handshake.
- Latency: grant at edge t; rsp_valid is high from cycle t+WIDTH+1. With rsp_ready tied high, throughput is one operation per WIDTH+2 cycles.
- Requester behaviour after grant: a requester deasserting req_valid or changing operands after its grant has no effect. An ungranted requester may change its operands freely.
- Fairness: a requester waits at most NREQ-1 operations before being granted.
- Boundaries:
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - Only one requester valid, repeatedly: it is granted every operation.
  - Carry never leaks between operations; it is cleared at every grant.

Optional Feature:
SERIAL_ADD_SAT_EN
- Defined: in DONE, if the final carry is 1, rsp_sum is forced to all ones; rsp_cout still reports the raw carry.
- Undefined: rsp_sum is the wrapped sum. No saturation logic is present.

Decomposition:
- Package serial_add_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - localparams for default WIDTH/NREQ
  - function computing the next round-robin grant
- Sub-module serial_add_cell: clk, rst, clr, en, a, b -> s, carry.
  - One full-adder bit with a registered carry; clr zeroes the carry synchronously.
  - The scheduler instantiates exactly one.

Test Plan (WIDTH=8, NREQ=4):
- Single request: requester 2 sends A=0x3C, B=0x15, rsp_ready=1 -> req_ready[2] for 1 cycle; 9 cycles later rsp_valid with rsp_id=2, rsp_sum=0x51, rsp_cout=0.
- Overflow: A=0xFF, B=0x01 -> rsp_sum=0x00, rsp_cout=1. With SERIAL_ADD_SAT_EN: rsp_sum=0xFF, rsp_cout=1.
- Round-robin: all 4 valid continuously with distinct operands -> grant order 0,1,2,3,0. Each rsp_id carries the correct sum, and no carry leaks between operations.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> outputs stable, busy=1, no req_ready asserted; release -> back to IDLE and the next grant occurs the following cycle.
- Reset mid-SHIFT: assert rst at bit 4 of an operation -> next cycle state=IDLE, rsp_valid=0, rr_ptr=0. A subsequent request 0x01+0x01 returns 0x02.
- Operand change after grant: requester 1 changes A from 0x10 to 0xAA the cycle after its grant, B=0x01 -> result is 0x11.
